// File: rtl/instruction_queue_if.sv
// Fetch-side bundle of the instruction queue: memory read channel, flush redirect and
// the head/occupancy view presented to decode. master = queue, slave = its environment.
interface instruction_queue_if #(
  parameter int width = 32,
  parameter int size  = 8
);
  localparam int cw = $clog2(size) + 1;

  logic             instr_mem_read;
  logic [width-1:0] instr_mem_address;
  logic             instr_mem_resp;
  logic [width-1:0] instr_mem_rdata;
  logic             instr_q_dequeue;
  logic             flush;
  logic [width-1:0] flush_pc;
  logic             instr_q_empty;
  logic             instr_q_full;
  logic [width-1:0] head_pc;
  logic [width-1:0] head_instr;
  logic [cw-1:0]    count;

  modport master (
    output instr_mem_read, instr_mem_address,
    output instr_q_empty, instr_q_full, head_pc, head_instr, count,
    input  instr_mem_resp, instr_mem_rdata, instr_q_dequeue, flush, flush_pc
  );

  modport slave (
    input  instr_mem_read, instr_mem_address,
    input  instr_q_empty, instr_q_full, head_pc, head_instr, count,
    output instr_mem_resp, instr_mem_rdata, instr_q_dequeue, flush, flush_pc
  );
endinterface

// File: rtl/instruction_queue.sv
// Instruction queue: sequential fetch into a circular {pc, instr} FIFO ahead of the ROB.
// Define IQ_BYPASS_EN for zero-latency fall-through of a response into an empty queue.
module instruction_queue #(
  parameter int               width    = 32,
  parameter int               size     = 8,
  parameter logic [width-1:0] start_pc = 32'h0000_0060
) (
  input logic               clk,
  input logic               rst,
  instruction_queue_if.master q
);
  localparam int aw = $clog2(size);
  localparam int cw = aw + 1;
  localparam logic [cw-1:0] full_count = cw'(size);

  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

  typedef struct packed {
    logic [width-1:0] pc;
    logic [width-1:0] instr;
  } entry_t;

  state_t           state, state_next;
  entry_t           entries [size];
  logic [aw-1:0]    rd, wr;
  logic [cw-1:0]    cnt, cnt_next;
  logic [width-1:0] fetch_pc;
  logic             accept, bypass_hit, write_en, deq_en;

  // A response is only meaningful for a live (non-stale) request that is not being flushed.
  assign accept = (state == FETCH) && q.instr_mem_resp && !q.flush;

`ifdef IQ_BYPASS_EN
  assign bypass_hit = accept && (cnt == '0);
`else
  assign bypass_hit = 1'b0;
`endif

  // A fall-through word popped in its arrival cycle never touches storage.
  assign write_en = accept && !(bypass_hit && q.instr_q_dequeue);
  assign deq_en   = q.instr_q_dequeue && (cnt != '0) && !q.flush;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cnt_next = cnt;
    if (write_en && !deq_en)      cnt_next = cnt + cw'(1);
    else if (!write_en && deq_en) cnt_next = cnt - cw'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (q.flush) begin
      state_next = (q.instr_mem_read && !q.instr_mem_resp) ? DISCARD : FETCH;
    end else begin
      unique case (state)
        FETCH:   if (q.instr_mem_resp) state_next = (cnt_next == full_count) ? HOLD : FETCH;
        HOLD:    if (cnt_next != full_count) state_next = FETCH;
        DISCARD: if (q.instr_mem_resp) state_next = FETCH;
        default: state_next = FETCH;
      endcase
    end
  end

  always_comb begin
    q.instr_mem_read    = (state != HOLD);
    q.instr_mem_address = fetch_pc;
    q.count             = cnt;
    q.instr_q_full      = (cnt == full_count);
    if (bypass_hit) begin
      q.head_pc       = fetch_pc;
      q.head_instr    = q.instr_mem_rdata;
      q.instr_q_empty = 1'b0;
    end else begin
      q.head_pc       = entries[rd].pc;
      q.head_instr    = entries[rd].instr;
      q.instr_q_empty = (cnt == '0);
    end
  end

  // NOTE: entries are cleared by reset because the empty queue must still present a zero head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= start_pc;
      rd       <= '0;
      wr       <= '0;
      cnt      <= '0;
      for (int i = 0; i < size; i++) entries[i] <= '0;
    end else if (q.flush) begin
      fetch_pc <= q.flush_pc;
      rd       <= '0;
      wr       <= '0;
      cnt      <= '0;
    end else begin
      if (write_en) begin
        entries[wr] <= '{pc: fetch_pc, instr: q.instr_mem_rdata};
        wr          <= wr + aw'(1);
      end
      if (accept) fetch_pc <= fetch_pc + width'(4);
      if (deq_en) rd <= rd + aw'(1);
      cnt <= cnt_next;
    end
  end
endmodule

// File: tb/tb_instruction_queue.sv
// Self-checking bench for instruction_queue: directed scenarios then random traffic,
// all compared against a queue-based reference model of fetch/flush/dequeue behaviour.
module tb_instruction_queue;
  localparam int          WIDTH    = 32;
  localparam int          SIZE     = 8;
  localparam logic [31:0] START_PC = 32'h0000_0060;
`ifdef IQ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instruction_queue_if #(.width(WIDTH), .size(SIZE)) mif ();

  instruction_queue #(.width(WIDTH), .size(SIZE), .start_pc(START_PC)) dut (
    .clk (clk),
    .rst (rst),
    .q   (mif.master)
  );

  int n_vec = 0;
  int n_err = 0;

  item_t       mq[$];
  logic [31:0] m_pc    = START_PC;
  bit          m_stale = 1'b0;

  logic        last_empty;
  logic [31:0] last_addr, last_head_pc, last_head_instr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    mif.instr_mem_resp  = 1'b0;
    mif.instr_mem_rdata = '0;
    mif.instr_q_dequeue = 1'b0;
    mif.flush           = 1'b0;
    mif.flush_pc        = '0;
  endtask

  function automatic bit model_read();
    return mq.size() < SIZE;
  endfunction

  // One clock cycle: drive at the falling edge, check combinational outputs against the
  // model, advance the model, then return just after the rising edge with inputs idle.
  task automatic step(input bit resp, input logic [31:0] rdata, input bit deq,
                      input bit fl, input logic [31:0] fpc);
    bit rd_exp, hit, accept;
    @(negedge clk);
    mif.instr_mem_resp  = resp;
    mif.instr_mem_rdata = rdata;
    mif.instr_q_dequeue = deq;
    mif.flush           = fl;
    mif.flush_pc        = fpc;
    #1;
    last_empty      = mif.instr_q_empty;
    last_addr       = mif.instr_mem_address;
    last_head_pc    = mif.head_pc;
    last_head_instr = mif.head_instr;

    rd_exp = model_read();
    hit    = BYPASS && (mq.size() == 0) && rd_exp && !m_stale && resp && !fl;
    check("read", mif.instr_mem_read, rd_exp);
    if (rd_exp) check("address", mif.instr_mem_address, m_pc);
    check("count", mif.count, mq.size());
    check("full", mif.instr_q_full, mq.size() == SIZE);
    check("empty", mif.instr_q_empty, !(hit || mq.size() != 0));
    if (hit) begin
      check("bypass_pc", mif.head_pc, m_pc);
      check("bypass_instr", mif.head_instr, rdata);
    end else if (mq.size() != 0) begin
      check("head_pc", mif.head_pc, mq[0].pc);
      check("head_instr", mif.head_instr, mq[0].instr);
    end

    if (fl) begin
      m_stale = rd_exp && !resp;
      mq.delete();
      m_pc = fpc;
    end else begin
      accept = rd_exp && resp && !m_stale;
      if (rd_exp && resp && m_stale) m_stale = 1'b0;
      if (deq && mq.size() != 0) void'(mq.pop_front());
      if (accept) begin
        if (!(hit && deq)) mq.push_back('{pc: m_pc, instr: rdata});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    #3;
    check("rst_count", mif.count, 0);
    check("rst_empty", mif.instr_q_empty, 1'b1);
    check("rst_full", mif.instr_q_full, 1'b0);
    check("rst_head_pc", mif.head_pc, 0);
    check("rst_head_instr", mif.head_instr, 0);
    #9 rst = 1'b1;

    // Fill from reset with one response per cycle.
    for (int i = 0; i < SIZE; i++) begin
      step(1'b1, $urandom, 1'b0, 1'b0, '0);
      check("fill_addr", last_addr, START_PC + 32'(4 * i));
    end
    check("full_flag", mif.instr_q_full, 1'b1);
    check("full_read", mif.instr_mem_read, 1'b0);
    check("full_count", mif.count, SIZE);
    check("full_head_pc", mif.head_pc, 32'h60);

    // Single dequeue from full re-opens fetch at 0x80, then refills across the wrap.
    step(1'b0, '0, 1'b1, 1'b0, '0);
    check("deq_count", mif.count, 7);
    check("deq_head_pc", mif.head_pc, 32'h64);
    check("deq_read", mif.instr_mem_read, 1'b1);
    check("deq_addr", mif.instr_mem_address, 32'h80);
    step(1'b1, $urandom, 1'b0, 1'b0, '0);
    check("wrap_count", mif.count, SIZE);
    for (int i = 0; i < SIZE; i++) step(1'b0, '0, 1'b1, 1'b0, '0);
    check("wrap_last_pc", last_head_pc, 32'h80);
    check("drain_empty", mif.instr_q_empty, 1'b1);

    // Flush with a request outstanding; the late response must be dropped.
    step(1'b0, '0, 1'b0, 1'b1, 32'h200);
    step(1'b0, '0, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b0, '0);
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, '0);
    check("stale_empty", mif.instr_q_empty, 1'b1);
    check("stale_addr", mif.instr_mem_address, 32'h200);
    step(1'b1, $urandom, 1'b0, 1'b0, '0);
    check("redirect_head_pc", mif.head_pc, 32'h200);

    // Flush coinciding with a response and a dequeue.
    step(1'b1, $urandom, 1'b1, 1'b1, 32'h300);
    check("flush_resp_count", mif.count, 0);
    check("flush_resp_addr", mif.instr_mem_address, 32'h300);
    step(1'b1, $urandom, 1'b0, 1'b0, '0);
    check("no_discard_count", mif.count, 1);
    check("no_discard_pc", mif.head_pc, 32'h300);

    // Response into an empty queue with a simultaneous dequeue.
    step(1'b0, '0, 1'b1, 1'b0, '0);
    step(1'b1, 32'h0050_0093, 1'b1, 1'b0, '0);
    check("byp_empty", last_empty, BYPASS ? 1'b0 : 1'b1);
    if (BYPASS) begin
      check("byp_instr", last_head_instr, 32'h0050_0093);
      check("byp_count", mif.count, 0);
    end else begin
      check("nobyp_count", mif.count, 1);
      check("nobyp_instr", mif.head_instr, 32'h0050_0093);
    end

    // Random traffic with occasional flushes.
    for (int i = 0; i < 600; i++) begin
      step(model_read() && ($urandom_range(2) != 0), $urandom, 1'($urandom_range(1)),
           ($urandom_range(39) == 0), $urandom & 32'hFFFF_FFFC);
    end

    // Asynchronous reset with five entries queued.
    step(1'b0, '0, 1'b0, 1'b1, 32'h1000);
    for (int i = 0; i < 40 && mq.size() < 5; i++) step(model_read(), $urandom, 1'b0, 1'b0, '0);
    check("pre_rst_count", mif.count, 5);
    #2 rst = 1'b0;
    #1;
    check("async_count", mif.count, 0);
    check("async_empty", mif.instr_q_empty, 1'b1);
    mq.delete();
    m_pc    = START_PC;
    m_stale = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0, '0);
    check("post_rst_addr", last_addr, 32'h60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/instruction_queue.md
Name: instruction_queue

Overview:
- Fetch-side buffer that sits directly upstream of the reorder buffer.
- Drives instruction-memory reads at a sequential PC and stores returned words with their PC in a circular FIFO.
- Presents the FIFO head to the ROB/decode, which pops it with instr_q_dequeue.
- On flush, drops all queued and in-flight instructions and redirects fetch to flush_pc.

Parameters:
- width, 32, data/address width in bits.
- size, 8, FIFO depth in entries (power of 2, ≥2).
- start_pc, 32'h00000060, PC fetched first after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- instr_mem_read  out  1  fetch request; held high until instr_mem_resp.
- instr_mem_address  out  width  fetch PC.
- instr_mem_resp  in  1  read data valid this cycle.
- instr_mem_rdata  in  width  instruction word.
- instr_q_dequeue  in  1  consumer pops head this cycle.
- flush  in  1  mispredict redirect.
- flush_pc  in  width  new fetch PC.
- instr_q_empty  out  1  no valid head.
- instr_q_full  out  1  count == size.
- head_pc  out  width  PC of head entry.
- head_instr  out  width  instruction at head.
- count  out  $clog2(size)+1  occupied entries.

Behaviour:
- Storage: entries {pc, instr}; read pointer rd and write pointer wr, each $clog2(size) bits, wrapping modulo size; separate count register. full = (count == size); empty = (count == 0).
- FSM states:
  - FETCH: read asserted, waiting for resp.
  - HOLD: read low because the queue is full.
  - DISCARD: read asserted; a stale request is outstanding after a flush.
- Reset (rst=0, async):
  - state=FETCH, fetch_pc=start_pc, rd=wr=count=0.
  - instr_mem_read=1 on the first cycle after deassertion.
  - instr_q_empty=1, instr_q_full=0.
  - head_pc=0, head_instr=0; all entries zeroed.
- instr_mem_address = fetch_pc whenever read is high.
- FETCH, resp=1:
  - Enqueue {fetch_pc, rdata} at wr (subject to the bypass rule in the Optional Feature).
  - fetch_pc += 4.
  - Next state: HOLD if post-update count == size, else FETCH.
  - Only one request is ever outstanding.
- HOLD: when count < size (after a dequeue), go to FETCH next cycle.
- DISCARD: on resp, drop the data, go to FETCH, fetch_pc unchanged (already = flush_pc).
- Dequeue:
  - If empty (and no bypass), dequeue is ignored.
  - Otherwise rd += 1, count −= 1.
  - Simultaneous enqueue and dequeue leaves count unchanged.
- Flush (priority over everything):
  - Same edge: rd=wr=count=0 and fetch_pc=flush_pc; dequeue that cycle is ignored.
  - If read was high and resp=0 that cycle, next state = DISCARD; otherwise FETCH.
  - A resp arriving in the flush cycle is dropped.
- Wrap-around: wr/rd roll from size−1 to 0; entry order is preserved across the wrap.
- Outputs head_pc/head_instr are combinational from entry[rd] (or from the bypass path).
- Reset asserted mid-request: the queue clears immediately; the memory response of the aborted request is ignored by the memory-side protocol.

Optional Feature:
- Macro: IQ_BYPASS_EN.
- Defined (fall-through):
  - If count==0 and state==FETCH and resp=1, then head = {fetch_pc, rdata} combinationally and instr_q_empty=0 in that same cycle.
  - If instr_q_dequeue=1 that cycle, the word is consumed and not written (count stays 0); otherwise it is written normally.
  - Zero-cycle fetch-to-ROB latency.
- Undefined: instr_q_empty stays 1 until the cycle after the resp; minimum latency is one cycle.

Test Plan:
- Reset release, memory answers every request next cycle, no dequeue:
  - Addresses 0x60, 0x64, … 0x7C are fetched.
  - After 8 resps: instr_q_full=1, read=0, state HOLD, count=8, head_pc=0x60.
- From full, single dequeue:
  - count=7, head_pc=0x64.
  - Next cycle read=1 at address 0x80.
  - After resp: count=8, entry at wr index 0 holds pc 0x80 (wrap verified).
- Flush with request outstanding, flush_pc=0x200, resp arrives 3 cycles later carrying 0xDEADBEEF:
  - Data dropped, queue empty.
  - Next request address = 0x200; first queued head_pc=0x200.
- Flush in the same cycle as resp and dequeue:
  - count=0, resp data dropped, next address = flush_pc, no DISCARD state.
- IQ_BYPASS_EN defined, empty queue, resp=1 with rdata=0x00500093 and dequeue=1:
  - head_instr=0x00500093 and instr_q_empty=0 in that cycle; count stays 0.
- IQ_BYPASS_EN undefined, same stimulus:
  - instr_q_empty=1 in the resp cycle.
  - Next cycle head_instr=0x00500093, count=1.
- Async reset asserted mid-queue (count=5):
  - count=0, instr_q_empty=1 immediately, before the next clock edge.
  - After release, first address = 0x60.
